puf_crp_collector: RTL and testbench

- Challenge-issuing end of the ring-oscillator PUF handshake.
- Sweeps challenges 0..NUM_CHALL-1 into the PUF, waits for its level-valid ready, and captures each response.
- Enroll mode: stores the responses in an internal CRP table.
- Verify mode: compares fresh responses to the stored table, accumulates total Hamming distance and counts mismatching challenges.
- Sits between the PUF instance and the host/authentication logic.

---
 rtl/puf_crp_pkg.sv | 28 ++
 rtl/puf_popcount.sv | 18 +
 rtl/puf_crp_collector.sv | 188 ++++++++++++++++++
 tb/tb_puf_crp_collector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_crp_pkg.sv
// Shared definitions for the PUF challenge/response collector.
// State codes, mode encodings and the width helpers used by the ports.
package puf_crp_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRST    = 3'd1;
    localparam logic [2:0] ST_APPLY   = 3'd2;
    localparam logic [2:0] ST_GUARD   = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_CAPTURE = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic MODE_ENROLL = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

    function automatic int hd_width(input int num_chall, input int resp_w);
        return $clog2(num_chall * resp_w + 1);
    endfunction

    function automatic int cnt_width(input int num_chall);
        return $clog2(num_chall + 1);
    endfunction

    function automatic int pop_width(input int resp_w);
        return $clog2(resp_w + 1);
    endfunction

endpackage

// File: rtl/puf_popcount.sv
// Combinational population count of a response word.
module puf_popcount #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);

    // NOTE: combinational logic uses blocking '=' with a default assigned first, so no latch is inferred.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CNT_W'(value[i]);
        end
    end

endmodule

// File: rtl/puf_crp_collector.sv
// Sweeps challenges into a ring-oscillator PUF, enrolls or verifies responses against a CRP table.
// Optional macro PUF_CRP_MAJORITY_EN: three samples per challenge, bitwise majority vote.
module puf_crp_collector
    import puf_crp_pkg::*;
#(
    parameter int CHALL_W   = 8,
    parameter int RESP_W    = 8,
    parameter int NUM_CHALL = 256,
    parameter int GUARD     = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      mode,
    output logic                                      puf_en,
    output logic                                      puf_rst,
    output logic [CHALL_W-1:0]                        puf_chall,
    input  logic [RESP_W-1:0]                         puf_resp,
    input  logic                                      puf_ready,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      enrolled,
    output logic [hd_width(NUM_CHALL, RESP_W)-1:0]    hd_total,
    output logic [cnt_width(NUM_CHALL)-1:0]           mismatch_cnt,
    output logic [cnt_width(NUM_CHALL)-1:0]           timeout_cnt,
    input  logic [CHALL_W-1:0]                        rd_addr,
    output logic [RESP_W-1:0]                         rd_data
);

    localparam int HD_W   = hd_width(NUM_CHALL, RESP_W);
    localparam int CNT_W  = cnt_width(NUM_CHALL);
    localparam int POP_W  = pop_width(RESP_W);
    localparam int GCNT_W = $clog2(GUARD + 1);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CHALL_W-1:0] LAST_IDX   = CHALL_W'(NUM_CHALL - 1);
    localparam logic [GCNT_W-1:0]  GUARD_LAST = GCNT_W'(GUARD - 1);
    localparam logic [WCNT_W-1:0]  WAIT_LAST  = WCNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    logic [2:0]          state;
    logic                mode_r;
    logic [CHALL_W-1:0]  idx;
    logic [GCNT_W-1:0]   gcnt;
    logic [WCNT_W-1:0]   wcnt;
    logic [RESP_W-1:0]   cap;
    logic                tflag;
    logic [RESP_W-1:0]   crp_mem [2**CHALL_W];
    logic [RESP_W-1:0]   sample;
    logic                sample_done;
    logic [RESP_W-1:0]   diff;
    logic [POP_W-1:0]    pop;
    logic [HD_W:0]       hd_sum;
    logic [HD_W-1:0]     hd_next;

`ifdef PUF_CRP_MAJORITY_EN
    logic [1:0]          samp_n;
    logic [RESP_W-1:0]   s0, s1;
    logic [RESP_W-1:0]   maj;
    assign maj = (s0 & s1) | (s0 & sample) | (s1 & sample);
`endif

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign puf_rst     = (state == ST_PRST);
    assign sample      = puf_ready ? puf_resp : '0;
    assign sample_done = puf_ready || (wcnt == WAIT_LAST);
    assign diff        = cap ^ crp_mem[idx];

    puf_popcount #(.W(RESP_W), .CNT_W(POP_W)) u_popcount (
        .value (diff),
        .count (pop)
    );

    // Hamming-distance accumulator clamps at its maximum instead of wrapping.
    assign hd_sum  = {1'b0, hd_total} + (HD_W + 1)'(pop);
    assign hd_next = hd_sum[HD_W] ? '1 : hd_sum[HD_W-1:0];

    // NOTE: sequential state uses non-blocking '<=' so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mode_r       <= MODE_ENROLL;
            idx          <= '0;
            gcnt         <= '0;
            wcnt         <= '0;
            cap          <= '0;
            tflag        <= 1'b0;
            puf_en       <= 1'b0;
            puf_chall    <= '0;
            enrolled     <= 1'b0;
            hd_total     <= '0;
            mismatch_cnt <= '0;
            timeout_cnt  <= '0;
`ifdef PUF_CRP_MAJORITY_EN
            samp_n       <= '0;
            s0           <= '0;
            s1           <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    mode_r       <= mode;
                    hd_total     <= '0;
                    mismatch_cnt <= '0;
                    timeout_cnt  <= '0;
                    idx          <= '0;
                    if (mode == MODE_VERIFY && !enrolled) begin
                        state <= ST_DONE;
                    end else begin
                        state  <= ST_PRST;
                        puf_en <= 1'b1;
                        if (mode == MODE_ENROLL) enrolled <= 1'b0;
                    end
                end
                ST_PRST: begin
                    puf_chall <= '0;
                    state     <= ST_APPLY;
                end
                ST_APPLY: state <= ST_GUARD;
                ST_GUARD: begin
                    if (gcnt == GUARD_LAST) begin
                        gcnt  <= '0;
                        state <= ST_WAIT;
                    end else begin
                        gcnt <= gcnt + GCNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (sample_done) begin
                        wcnt <= '0;
                        if (!puf_ready) tflag <= 1'b1;
`ifdef PUF_CRP_MAJORITY_EN
                        if (samp_n == 2'd2) begin
                            cap    <= maj;
                            samp_n <= '0;
                            state  <= ST_CAPTURE;
                        end else begin
                            if (samp_n == 2'd0) s0 <= sample;
                            else                s1 <= sample;
                            samp_n <= samp_n + 2'd1;
                            state  <= ST_GUARD;
                        end
`else
                        cap   <= sample;
                        state <= ST_CAPTURE;
`endif
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    tflag <= 1'b0;
                    if (tflag && timeout_cnt != CNT_MAX) timeout_cnt <= timeout_cnt + CNT_W'(1);
                    if (mode_r == MODE_VERIFY) begin
                        hd_total <= hd_next;
                        if (pop != '0 && mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    end
                    if (idx == LAST_IDX) begin
                        puf_en <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        idx       <= idx + CHALL_W'(1);
                        puf_chall <= idx + CHALL_W'(1);
                        state     <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    if (mode_r == MODE_ENROLL) enrolled <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the CRP table is deliberately not reset; enrolled alone says whether its contents are valid.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE && mode_r == MODE_ENROLL) crp_mem[idx] <= cap;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= crp_mem[rd_addr];
    end

endmodule

// File: tb/tb_puf_crp_collector.sv
// Scoreboarded bench for puf_crp_collector with a behavioural PUF model.
module tb_puf_crp_collector;

    localparam int CW      = 8;
    localparam int RW      = 8;
    localparam int NC      = 256;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 16;
    localparam int HD_W    = $clog2(NC * RW + 1);
    localparam int CNT_W   = $clog2(NC + 1);
    localparam int BUDGET  = 20000;

    logic             clk = 1'b0;
    logic             rst, start, mode;
    logic             puf_en, puf_rst, puf_ready;
    logic [CW-1:0]    puf_chall, rd_addr;
    logic [RW-1:0]    puf_resp, rd_data;
    logic             busy, done, enrolled;
    logic [HD_W-1:0]  hd_total;
    logic [CNT_W-1:0] mismatch_cnt, timeout_cnt;

    always #5 clk = ~clk;

    puf_crp_collector #(
        .CHALL_W(CW), .RESP_W(RW), .NUM_CHALL(NC), .GUARD(GUARD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .puf_en(puf_en), .puf_rst(puf_rst), .puf_chall(puf_chall),
        .puf_resp(puf_resp), .puf_ready(puf_ready),
        .busy(busy), .done(done), .enrolled(enrolled),
        .hd_total(hd_total), .mismatch_cnt(mismatch_cnt), .timeout_cnt(timeout_cnt),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // PUF model configuration
    logic [7:0] key;
    logic [7:0] flip_tab [NC];
    int         never_ch;
    bit         stale_mode, corrupt_mode;
    int         ready_delay;

    // Reference: expected table contents and enrollment flag
    logic [7:0] ref_tab [NC];
    bit         ref_enrolled;

    typedef struct { int hd; int mm; int to; bit enr; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] resp_of(input logic [7:0] c);
        return c ^ key ^ flip_tab[c];
    endfunction

    // Behavioural PUF: response is a function of the challenge; ready follows a delay after each change.
    initial begin
        logic [7:0] prev_chall, old_resp;
        int cnt;
        prev_chall = '0; old_resp = '0; cnt = 0;
        puf_ready = 1'b0; puf_resp = '0;
        forever begin
            @(negedge clk);
            if (puf_chall !== prev_chall) begin
                old_resp   = resp_of(prev_chall);
                prev_chall = puf_chall;
                cnt        = 0;
            end else if (puf_rst) begin
                cnt = 0;
            end else begin
                cnt++;
            end
            if (stale_mode) begin
                puf_ready = 1'b1;
                puf_resp  = (cnt >= GUARD) ? resp_of(puf_chall) : old_resp;
            end else begin
                puf_ready = puf_en && cnt >= ready_delay && int'(puf_chall) != never_ch;
                if (puf_ready)
                    puf_resp = resp_of(puf_chall) ^ ((corrupt_mode && cnt < ready_delay + 2) ? 8'hFF : 8'h00);
                else
                    puf_resp = 8'($urandom);
            end
        end
    end

    // Expected outcome of a sweep, from the table-level rules.
    task automatic predict(input bit m, output exp_t e);
        logic [7:0] fresh;
        int d;
        e = '{default: 0};
        if (m == 1'b1 && !ref_enrolled) begin
            e.enr = 1'b0;
            return;
        end
        for (int c = 0; c < NC; c++) begin
            if (c == never_ch) begin
                fresh = 8'h00;
                e.to++;
            end else begin
                fresh = resp_of(8'(c));
            end
            if (m == 1'b0) begin
                ref_tab[c] = fresh;
            end else begin
                d = $countones(fresh ^ ref_tab[c]);
                e.hd += d;
                if (d != 0) e.mm++;
            end
        end
        if (m == 1'b0) ref_enrolled = 1'b1;
        e.enr = ref_enrolled;
    endtask

    // Monitor: pop and compare whenever the DUT signals done.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst && done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("hd_total", hd_total, e.hd);
                    check("mismatch_cnt", mismatch_cnt, e.mm);
                    check("timeout_cnt", timeout_cnt, e.to);
                    @(posedge clk); #1;
                    check("done_one_cycle", done, 1'b0);
                    check("enrolled_after", enrolled, e.enr);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("sweep_finishes", busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_sweep(input bit m, input bit poke_busy);
        exp_t e;
        predict(m, e);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0;
        if (poke_busy) begin
            repeat (50) @(negedge clk);
            start = 1'b1; mode = ~m;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    task automatic clear_flips();
        for (int c = 0; c < NC; c++) flip_tab[c] = 8'h00;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; mode = 1'b0; rd_addr = '0;
        key = 8'hA5; never_ch = -1; stale_mode = 1'b0; corrupt_mode = 1'b0; ready_delay = 3;
        ref_enrolled = 1'b0;
        clear_flips();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_enrolled", enrolled, 1'b0);
        check("rst_puf_en", puf_en, 1'b0);
        check("rst_puf_rst", puf_rst, 1'b0);
        check("rst_puf_chall", puf_chall, 8'h00);
        check("rst_hd", hd_total, 0);
        check("rst_mm", mismatch_cnt, 0);
        check("rst_to", timeout_cnt, 0);
        check("rst_rd_data", rd_data, 8'h00);
        rst = 1'b0;

        // Enroll with a busy-time start pulse that must be ignored
        run_sweep(1'b0, 1'b1);
        read_check("rd_0x10", 8'h10, 8'hB5);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            a = 8'($urandom);
            read_check("rd_rand", a, ref_tab[a]);
        end

        run_sweep(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) flip_tab[c] = 8'h01;
        run_sweep(1'b1, 1'b0);

        // Randomized verify: random flips on a random subset, random ready delay
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NC; c++) flip_tab[c] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ready_delay = $urandom_range(0, 6);
            run_sweep(1'b1, 1'b0);
        end

        // Reset in the middle of an enroll sweep
        clear_flips();
        ready_delay = 3;
        @(negedge clk);
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (puf_chall != 8'd100 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("reach_chall_100", puf_chall, 8'd100);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_enrolled", enrolled, 1'b0);
        check("abort_puf_en", puf_en, 1'b0);
        check("abort_puf_chall", puf_chall, 8'h00);
        check("abort_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        ref_enrolled = 1'b0;
        read_check("table_kept", 8'd200, ref_tab[200]);
        run_sweep(1'b1, 1'b0);

        // Response lags the challenge with ready held high
        key = 8'h3C; stale_mode = 1'b1;
        run_sweep(1'b0, 1'b0);
        for (int c = 0; c < NC; c++) read_check("stale_entry", 8'(c), 8'(c) ^ 8'h3C);
        stale_mode = 1'b0;

        // One challenge never becomes ready
        key = 8'hA5; never_ch = 7;
        ready_delay = $urandom_range(0, 5);
        run_sweep(1'b0, 1'b0);
        read_check("timeout_entry", 8'h07, 8'h00);
        read_check("after_timeout_entry", 8'h08, 8'h08 ^ 8'hA5);
        never_ch = -1;

`ifdef PUF_CRP_MAJORITY_EN
        // First of three samples corrupted: majority vote hides it
        ready_delay = 3;
        run_sweep(1'b0, 1'b0);
        corrupt_mode = 1'b1;
        run_sweep(1'b1, 1'b1);
        corrupt_mode = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
